// File: rtl/stream2pvideo.sv
// Pixel stream (valid/ready, SOF on tuser, EOL on tlast) to parallel video
// (do/de/hs/vs) with configurable blanking and framing-error pulses.
module stream2pvideo #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tuser,
    input  logic                  s_tlast,
    input  logic [CNT_WIDTH-1:0]  cfg_hsize,
    input  logic [CNT_WIDTH-1:0]  cfg_vsize,
    input  logic [CNT_WIDTH-1:0]  cfg_hblank,
    input  logic [CNT_WIDTH-1:0]  cfg_vblank,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  frame_done,
    output logic                  err_sof,
    output logic                  err_len
);

    typedef enum logic [1:0] {S_WAIT_SOF, S_LINE, S_HBLANK, S_VBLANK} state_t;

    localparam logic [CNT_WIDTH-1:0] ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    state_t state_q, state_d;

    logic [CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0] blank_cnt_q, blank_cnt_d;
    logic [CNT_WIDTH-1:0] hsize_q, hsize_d;
    logic [CNT_WIDTH-1:0] vsize_q, vsize_d;
    logic [CNT_WIDTH-1:0] hblank_q, hblank_d;
    logic [CNT_WIDTH-1:0] vblank_q, vblank_d;

    logic [DATA_WIDTH-1:0] do_q, do_d;
    logic de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic fd_q, fd_d, esof_q, esof_d, elen_q, elen_d;

    logic sof_start, sof_bad, beat, line_end, frame_end, blank_done;

    always_comb begin
        sof_start  = s_tvalid && s_tuser;
        sof_bad    = sof_start && (line_cnt_q != ZERO || pix_cnt_q != ZERO);
        beat       = (state_q == S_LINE) && s_tvalid && !sof_bad;
        line_end   = beat && s_tlast;
        frame_end  = line_end && (line_cnt_q + ONE == vsize_q);
        blank_done = (blank_cnt_q + ONE) ==
                     ((state_q == S_HBLANK) ? hblank_q : vblank_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_WAIT_SOF: if (sof_start) state_d = S_LINE;
            S_LINE: begin
                if (sof_bad)
                    state_d = S_VBLANK;
                else if (line_end)
                    state_d = frame_end ? S_VBLANK : S_HBLANK;
            end
            S_HBLANK: if (blank_done) state_d = S_LINE;
            S_VBLANK: if (blank_done) state_d = S_WAIT_SOF;
        endcase
    end

    // Counters and per-frame config shadows; zero blank/vsize counts as one.
    always_comb begin
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        blank_cnt_d = ZERO;
        hsize_d     = hsize_q;
        vsize_d     = vsize_q;
        hblank_d    = hblank_q;
        vblank_d    = vblank_q;
        unique case (state_q)
            S_WAIT_SOF: begin
                pix_cnt_d  = ZERO;
                line_cnt_d = ZERO;
                if (sof_start) begin
                    hsize_d  = cfg_hsize;
                    vsize_d  = (cfg_vsize == ZERO) ? ONE : cfg_vsize;
                    hblank_d = (cfg_hblank == ZERO) ? ONE : cfg_hblank;
                    vblank_d = (cfg_vblank == ZERO) ? ONE : cfg_vblank;
                end
            end
            S_LINE: begin
                if (line_end) begin
                    pix_cnt_d  = ZERO;
                    line_cnt_d = line_cnt_q + ONE;
                end else if (beat) begin
                    pix_cnt_d = pix_cnt_q + ONE;
                end
            end
            S_HBLANK, S_VBLANK: begin
                blank_cnt_d = blank_done ? ZERO : blank_cnt_q + ONE;
            end
        endcase
    end

    // Sync outputs describe the state one cycle back, so they line up with de.
    always_comb begin
        s_tready = 1'b0;
        de_d     = beat;
        do_d     = beat ? s_tdata : do_q;
        hs_d     = 1'b1;
        vs_d     = 1'b1;
        fd_d     = 1'b0;
        esof_d   = 1'b0;
        elen_d   = 1'b0;
        unique case (state_q)
            S_WAIT_SOF: s_tready = !s_tuser;
            S_LINE: begin
                s_tready = !sof_bad;
                hs_d     = 1'b0;
                vs_d     = 1'b0;
                esof_d   = sof_bad;
                elen_d   = line_end && (pix_cnt_q + ONE != hsize_q);
            end
            S_HBLANK: vs_d = 1'b0;
            S_VBLANK: fd_d = (blank_cnt_q == ZERO);
        endcase
        if (rst) s_tready = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            blank_cnt_q <= '0;
            hsize_q     <= '0;
            vsize_q     <= ONE;
            hblank_q    <= ONE;
            vblank_q    <= ONE;
            do_q        <= '0;
            de_q        <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            fd_q        <= 1'b0;
            esof_q      <= 1'b0;
            elen_q      <= 1'b0;
        end else begin
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            hsize_q     <= hsize_d;
            vsize_q     <= vsize_d;
            hblank_q    <= hblank_d;
            vblank_q    <= vblank_d;
            do_q        <= do_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            fd_q        <= fd_d;
            esof_q      <= esof_d;
            elen_q      <= elen_d;
        end
    end

    assign do_o       = do_q;
    assign de_o       = de_q;
    assign hs_o       = hs_q;
    assign vs_o       = vs_q;
    assign frame_done = fd_q;
    assign err_sof    = esof_q;
    assign err_len    = elen_q;

endmodule

// File: tb/tb_stream2pvideo.sv
// Bench for stream2pvideo: randomized pixel streams compared against a
// frame-level model of expected pixels, blanking gaps and pulse counts.
module tb_stream2pvideo;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tready, s_tuser, s_tlast;
    logic [15:0] cfg_hsize, cfg_vsize, cfg_hblank, cfg_vblank;
    logic [7:0]  do_o;
    logic        de_o, hs_o, vs_o, frame_done, err_sof, err_len;

    stream2pvideo #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tuser(s_tuser), .s_tlast(s_tlast),
        .cfg_hsize(cfg_hsize), .cfg_vsize(cfg_vsize),
        .cfg_hblank(cfg_hblank), .cfg_vblank(cfg_vblank),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
        .frame_done(frame_done), .err_sof(err_sof), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] bq_data[$];
    bit         bq_user[$], bq_last[$];
    logic [7:0] exp_pix[$];
    bit         exp_first[$];
    int         exp_gap[$], exp_gvs[$];
    int         exp_fd, exp_es, exp_el, line_in_frame;

    bit         mon_en = 1'b0;
    bit         tr_de[$], tr_hs[$], tr_vs[$], tr_fd[$], tr_es[$], tr_el[$];
    logic [7:0] tr_do[$];

    logic [7:0] obs_pix[$];
    int         obs_gap[$], obs_gvs[$];
    int         obs_fd, obs_es, obs_el, obs_hs_bad, obs_ghs_bad;
    bit         es_vs_next, el_de;
    int         acc_cyc[$];

    always @(negedge clk) begin
        if (mon_en) begin
            tr_de.push_back(de_o);
            tr_do.push_back(do_o);
            tr_hs.push_back(hs_o);
            tr_vs.push_back(vs_o);
            tr_fd.push_back(frame_done);
            tr_es.push_back(err_sof);
            tr_el.push_back(err_len);
        end
    end

    function automatic int eff(input logic [15:0] v);
        return (v == 16'd0) ? 1 : int'(v);
    endfunction

    task automatic clear_model();
        bq_data.delete(); bq_user.delete(); bq_last.delete();
        exp_pix.delete(); exp_first.delete();
        exp_gap.delete(); exp_gvs.delete();
        exp_fd = 0; exp_es = 0; exp_el = 0; line_in_frame = 0;
        tr_de.delete(); tr_do.delete(); tr_hs.delete(); tr_vs.delete();
        tr_fd.delete(); tr_es.delete(); tr_el.delete();
    endtask

    task automatic reset_dut();
        mon_en = 1'b0;
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
    endtask

    // One line of len pixels; the frame ends when the line count reaches vsize.
    task automatic add_line(input int len, input bit sof);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d = 8'($urandom_range(255));
            bq_data.push_back(d);
            bq_user.push_back(sof && i == 0);
            bq_last.push_back(i == len - 1);
            exp_pix.push_back(d);
            exp_first.push_back(i == 0);
        end
        if (len != int'(cfg_hsize)) exp_el++;
        line_in_frame++;
        if (line_in_frame == eff(cfg_vsize)) begin
            exp_gap.push_back(eff(cfg_vblank) + 1);
            exp_gvs.push_back(1);
            exp_fd++;
            line_in_frame = 0;
        end else begin
            exp_gap.push_back(eff(cfg_hblank));
            exp_gvs.push_back(0);
        end
    endtask

    task automatic add_frame(input int w, input int h);
        for (int l = 0; l < h; l++) add_line(w, l == 0);
    endtask

    task automatic add_partial(input int len);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d = 8'($urandom_range(255));
            bq_data.push_back(d);
            bq_user.push_back(1'b0);
            bq_last.push_back(1'b0);
            exp_pix.push_back(d);
            exp_first.push_back(i == 0);
        end
        exp_es++;
        exp_fd++;
        line_in_frame = 0;
    endtask

    task automatic add_garbage(input int n);
        for (int i = 0; i < n; i++) begin
            bq_data.push_back(8'($urandom_range(255)));
            bq_user.push_back(1'b0);
            bq_last.push_back(1'($urandom_range(1)));
        end
    endtask

    task automatic finish_model();
        if (exp_gap.size() > 0) begin
            void'(exp_gap.pop_back());
            void'(exp_gvs.pop_back());
        end
    endtask

    task automatic drive(input int pct);
        int  idx = 0;
        int  cyc = 0;
        bit  hs;
        acc_cyc.delete();
        while (idx < bq_data.size() && cyc < 3000) begin
            s_tvalid = ($urandom_range(99) < pct);
            s_tdata  = bq_data[idx];
            s_tuser  = bq_user[idx];
            s_tlast  = bq_last[idx];
            @(negedge clk);
            hs = s_tvalid && s_tready;
            @(posedge clk);
            #1;
            if (hs) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
            cyc++;
        end
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
        n_total++;
        if (idx != bq_data.size())
            $display("FAIL drive_timeout: accepted %0d beats, required %0d", idx, bq_data.size());
        else n_pass++;
    endtask

    task automatic analyze();
        int dc[$];
        int n;
        int g, v1, v0;
        n = tr_de.size();
        obs_pix.delete(); obs_gap.delete(); obs_gvs.delete();
        obs_fd = 0; obs_es = 0; obs_el = 0; obs_hs_bad = 0; obs_ghs_bad = 0;
        es_vs_next = 1'b0; el_de = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (tr_de[c]) begin
                dc.push_back(c);
                obs_pix.push_back(tr_do[c]);
            end
            if (tr_fd[c]) obs_fd++;
            if (tr_es[c]) begin
                if (obs_es == 0 && c + 1 < n) es_vs_next = tr_vs[c+1];
                obs_es++;
            end
            if (tr_el[c]) begin
                if (obs_el == 0) el_de = tr_de[c];
                obs_el++;
            end
        end
        for (int i = 0; i < dc.size(); i++) begin
            if (tr_hs[dc[i]]) obs_hs_bad++;
            if (i > 0) begin
                g = dc[i] - dc[i-1] - 1;
                if (i < exp_first.size() && !exp_first[i])
                    for (int c = dc[i-1] + 1; c < dc[i]; c++)
                        if (tr_hs[c]) obs_hs_bad++;
                if (g > 0) begin
                    v1 = 1; v0 = 1;
                    for (int c = dc[i-1] + 1; c < dc[i]; c++) begin
                        if (tr_vs[c]) v0 = 0; else v1 = 0;
                        if (!tr_hs[c]) obs_ghs_bad++;
                    end
                    obs_gap.push_back(g);
                    obs_gvs.push_back(v1 == 1 ? 1 : (v0 == 1 ? 0 : 2));
                end
            end
        end
    endtask

    task automatic run_stream(input int pct, input int tail);
        mon_en = 1'b1;
        drive(pct);
        repeat (tail) @(posedge clk);
        #1 mon_en = 1'b0;
        analyze();
    endtask

    function automatic int pix_diff();
        int d = 0;
        if (obs_pix.size() != exp_pix.size()) d = 1000;
        for (int i = 0; i < obs_pix.size() && i < exp_pix.size(); i++)
            if (obs_pix[i] !== exp_pix[i]) d++;
        return d;
    endfunction

    function automatic int gap_diff();
        int d = 0;
        if (obs_gap.size() != exp_gap.size()) return 1000;
        for (int i = 0; i < obs_gap.size(); i++)
            if (obs_gap[i] != exp_gap[i] || obs_gvs[i] != exp_gvs[i]) d++;
        return d;
    endfunction

    task automatic set_cfg(input int h, input int v, input int hb, input int vb);
        cfg_hsize = 16'(h); cfg_vsize = 16'(v);
        cfg_hblank = 16'(hb); cfg_vblank = 16'(vb);
    endtask

    task automatic test_reset();
        set_cfg(4, 2, 3, 5);
        rst = 1'b1; s_tvalid = 1'b1; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = 8'hA5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (s_tready !== 1'b0) $display("FAIL rst_tready: got %b expected 0", s_tready); else n_pass++;
        n_total++; if (de_o !== 1'b0) $display("FAIL rst_de: got %b expected 0", de_o); else n_pass++;
        n_total++; if (do_o !== 8'h00) $display("FAIL rst_do: got %h expected 00", do_o); else n_pass++;
        n_total++; if (hs_o !== 1'b1) $display("FAIL rst_hs: got %b expected 1", hs_o); else n_pass++;
        n_total++; if (vs_o !== 1'b1) $display("FAIL rst_vs: got %b expected 1", vs_o); else n_pass++;
        n_total++; if (frame_done !== 1'b0) $display("FAIL rst_fd: got %b expected 0", frame_done); else n_pass++;
        n_total++; if (err_sof !== 1'b0) $display("FAIL rst_esof: got %b expected 0", err_sof); else n_pass++;
        n_total++; if (err_len !== 1'b0) $display("FAIL rst_elen: got %b expected 0", err_len); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_total++; if (s_tready !== 1'b1) $display("FAIL wait_drop_ready: got %b expected 1", s_tready); else n_pass++;
        s_tvalid = 1'b0;
    endtask

    task automatic test_full_frame();
        reset_dut();
        set_cfg(4, 2, 3, 5);
        add_frame(4, 2); add_frame(4, 2); finish_model();
        run_stream(100, 20);
        n_total++; if (pix_diff() != 0) $display("FAIL full_pixels: %0d wrong of %0d, got count %0d", pix_diff(), exp_pix.size(), obs_pix.size()); else n_pass++;
        n_total++; if (gap_diff() != 0) $display("FAIL full_gaps: got %0d gaps, %0d differ from required %0d", obs_gap.size(), gap_diff(), exp_gap.size()); else n_pass++;
        n_total++; if (obs_ghs_bad != 0) $display("FAIL full_gap_hs: got %0d gap cycles with hs=0, expected 0", obs_ghs_bad); else n_pass++;
        n_total++; if (obs_hs_bad != 0) $display("FAIL full_line_hs: got %0d line cycles with hs=1, expected 0", obs_hs_bad); else n_pass++;
        n_total++; if (obs_fd != exp_fd) $display("FAIL full_frame_done: got %0d expected %0d", obs_fd, exp_fd); else n_pass++;
        n_total++; if (obs_es + obs_el != 0) $display("FAIL full_errors: got %0d expected 0", obs_es + obs_el); else n_pass++;
    endtask

    task automatic test_stall();
        reset_dut();
        set_cfg(4, 2, 3, 5);
        add_frame(4, 2); finish_model();
        run_stream(50, 30);
        n_total++; if (pix_diff() != 0) $display("FAIL stall_pixels: %0d wrong, got count %0d expected %0d", pix_diff(), obs_pix.size(), exp_pix.size()); else n_pass++;
        n_total++; if (obs_hs_bad != 0) $display("FAIL stall_line_hs: got %0d cycles with hs=1, expected 0", obs_hs_bad); else n_pass++;
        n_total++; if (obs_fd != 1) $display("FAIL stall_frame_done: got %0d expected 1", obs_fd); else n_pass++;
        n_total++; if (obs_es + obs_el != 0) $display("FAIL stall_errors: got %0d expected 0", obs_es + obs_el); else n_pass++;
    endtask

    task automatic test_drop();
        int exp_acc[4] = '{0, 1, 2, 4};
        reset_dut();
        set_cfg(4, 2, 2, 2);
        add_garbage(3); add_frame(4, 2); finish_model();
        run_stream(100, 20);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (i >= acc_cyc.size() || acc_cyc[i] != exp_acc[i])
                $display("FAIL drop_accept_cycle%0d: got %0d expected %0d", i, (i < acc_cyc.size()) ? acc_cyc[i] : -1, exp_acc[i]);
            else n_pass++;
        end
        n_total++; if (pix_diff() != 0) $display("FAIL drop_pixels: %0d wrong, got count %0d expected %0d", pix_diff(), obs_pix.size(), exp_pix.size()); else n_pass++;
        n_total++; if (gap_diff() != 0) $display("FAIL drop_gaps: %0d differ, got %0d expected %0d", gap_diff(), obs_gap.size(), exp_gap.size()); else n_pass++;
        n_total++; if (obs_fd != 1) $display("FAIL drop_frame_done: got %0d expected 1", obs_fd); else n_pass++;
    endtask

    task automatic test_err_sof();
        reset_dut();
        set_cfg(4, 4, 2, 3);
        add_line(4, 1'b1); add_partial(2); add_frame(4, 4);
        run_stream(100, 25);
        n_total++; if (obs_es != exp_es) $display("FAIL sof_err_count: got %0d expected %0d", obs_es, exp_es); else n_pass++;
        n_total++; if (es_vs_next !== 1'b1) $display("FAIL sof_vs_next: got %b expected 1", es_vs_next); else n_pass++;
        n_total++; if (pix_diff() != 0) $display("FAIL sof_pixels: %0d wrong, got count %0d expected %0d", pix_diff(), obs_pix.size(), exp_pix.size()); else n_pass++;
        n_total++; if (obs_fd != exp_fd) $display("FAIL sof_frame_done: got %0d expected %0d", obs_fd, exp_fd); else n_pass++;
        n_total++; if (obs_el != 0) $display("FAIL sof_len_err: got %0d expected 0", obs_el); else n_pass++;
    endtask

    task automatic test_err_len();
        reset_dut();
        set_cfg(4, 2, 3, 2);
        add_line(3, 1'b1); add_line(4, 1'b0); finish_model();
        run_stream(100, 20);
        n_total++; if (obs_el != exp_el) $display("FAIL len_err_count: got %0d expected %0d", obs_el, exp_el); else n_pass++;
        n_total++; if (el_de !== 1'b1) $display("FAIL len_err_with_de: got %b expected 1", el_de); else n_pass++;
        n_total++; if (pix_diff() != 0) $display("FAIL len_pixels: %0d wrong, got count %0d expected %0d", pix_diff(), obs_pix.size(), exp_pix.size()); else n_pass++;
        n_total++; if (gap_diff() != 0) $display("FAIL len_gaps: %0d differ, got %0d expected %0d", gap_diff(), obs_gap.size(), exp_gap.size()); else n_pass++;
        n_total++; if (obs_fd != 1 || obs_es != 0) $display("FAIL len_fd_sof: got fd=%0d esof=%0d expected 1/0", obs_fd, obs_es); else n_pass++;
    endtask

    task automatic test_zero_cfg();
        reset_dut();
        set_cfg(3, 0, 0, 0);
        add_frame(3, 1); add_frame(3, 1); finish_model();
        run_stream(100, 15);
        n_total++; if (pix_diff() != 0) $display("FAIL zero_pixels: %0d wrong, got count %0d expected %0d", pix_diff(), obs_pix.size(), exp_pix.size()); else n_pass++;
        n_total++; if (gap_diff() != 0) $display("FAIL zero_gaps: %0d differ, got %0d expected %0d", gap_diff(), obs_gap.size(), exp_gap.size()); else n_pass++;
        n_total++; if (obs_fd != 2) $display("FAIL zero_frame_done: got %0d expected 2", obs_fd); else n_pass++;
    endtask

    task automatic test_random_cfg();
        for (int it = 0; it < 3; it++) begin
            reset_dut();
            set_cfg($urandom_range(5, 1), $urandom_range(3, 1),
                    $urandom_range(3, 0), $urandom_range(3, 0));
            add_frame(int'(cfg_hsize), int'(cfg_vsize));
            add_frame(int'(cfg_hsize), int'(cfg_vsize));
            finish_model();
            run_stream(100, 20);
            n_total++; if (pix_diff() != 0) $display("FAIL rnd%0d_pixels: %0d wrong, got count %0d expected %0d", it, pix_diff(), obs_pix.size(), exp_pix.size()); else n_pass++;
            n_total++; if (gap_diff() != 0) $display("FAIL rnd%0d_gaps: %0d differ, got %0d expected %0d", it, gap_diff(), obs_gap.size(), exp_gap.size()); else n_pass++;
            n_total++; if (obs_fd != exp_fd) $display("FAIL rnd%0d_frame_done: got %0d expected %0d", it, obs_fd, exp_fd); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        set_cfg(4, 2, 2, 2);
        s_tvalid = 1'b1; s_tuser = 1'b1; s_tdata = 8'h11;
        @(posedge clk); #1;
        @(posedge clk); #1 s_tuser = 1'b0; s_tdata = 8'h22;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++; if (de_o !== 1'b1) $display("FAIL mid_de_before: got %b expected 1", de_o); else n_pass++;
        #2 rst = 1'b1; s_tvalid = 1'b0;
        @(negedge clk);
        n_total++; if (de_o !== 1'b0) $display("FAIL mid_rst_de: got %b expected 0", de_o); else n_pass++;
        n_total++; if (hs_o !== 1'b1 || vs_o !== 1'b1) $display("FAIL mid_rst_hsvs: got %b%b expected 11", hs_o, vs_o); else n_pass++;
        n_total++; if (s_tready !== 1'b0) $display("FAIL mid_rst_tready: got %b expected 0", s_tready); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        clear_model();
        add_frame(4, 2); finish_model();
        run_stream(100, 20);
        n_total++; if (pix_diff() != 0) $display("FAIL mid_resume_pixels: %0d wrong, got count %0d expected %0d", pix_diff(), obs_pix.size(), exp_pix.size()); else n_pass++;
        n_total++; if (obs_fd != 1) $display("FAIL mid_resume_fd: got %0d expected 1", obs_fd); else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_stall();
        test_drop();
        test_err_sof();
        test_err_len();
        test_zero_cfg();
        test_random_cfg();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
